// File: rtl/enemy_lane_ctrl.sv
// Purpose: per-lane enemy controller producing pos/hit for the sprite/damage stage plus score/miss events.
// Latency: every output is registered; inputs sampled at an edge are reflected one cycle later.
// Backpressure: none; spawns arriving while the lane is busy (or entering IDLE) are dropped, not queued.
module enemy_lane_ctrl #(
    parameter int MAX_POS       = 10,
    parameter int HIT_LO        = 7,
    parameter int DEFEAT_TICKS  = 4,
    parameter int CONTACT_TICKS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       spawn,
    input  logic       attack,
    output logic [4:0] pos,
    output logic       hit,
    output logic       score_pulse,
    output logic       miss_pulse,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WALK,
        S_CONTACT,
        S_DEFEAT
    } state_t;

    localparam logic [4:0] MAX_P   = 5'(MAX_POS);
    localparam logic [4:0] HIT_P   = 5'(HIT_LO);
    localparam logic [3:0] CT_LAST = 4'(CONTACT_TICKS - 1);
    localparam logic [3:0] DT_LAST = 4'(DEFEAT_TICKS - 1);

    state_t     state;
    state_t     state_nxt;
    logic [4:0] pos_nxt;
    logic       hit_nxt;
    logic       score_nxt;
    logic       miss_nxt;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic       attack_q;
    logic       atk_edge;

    // Only a fresh key press counts; holding the key never re-fires.
    assign atk_edge = attack & ~attack_q;

    // State, shared tick counter, edge register and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= 4'd0;
            attack_q    <= 1'b0;
            pos         <= 5'd0;
            hit         <= 1'b1;
            score_pulse <= 1'b0;
            miss_pulse  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            attack_q    <= attack;
            pos         <= pos_nxt;
            hit         <= hit_nxt;
            score_pulse <= score_nxt;
            miss_pulse  <= miss_nxt;
            busy        <= (state_nxt != S_IDLE);
        end
    end

    // Next-state and next-output logic; a valid attack outranks a tick in the same cycle.
    always_comb begin
        state_nxt = state;
        pos_nxt   = pos;
        hit_nxt   = hit;
        cnt_nxt   = cnt;
        score_nxt = 1'b0;
        miss_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                pos_nxt = 5'd0;
                hit_nxt = 1'b1;
                if (spawn) begin
                    state_nxt = S_WALK;
                    pos_nxt   = 5'd1;
                    hit_nxt   = 1'b0;
                    cnt_nxt   = 4'd0;
                end
            end
            S_WALK: begin
                hit_nxt = 1'b0;
                if (atk_edge && (pos >= HIT_P)) begin
                    state_nxt = S_DEFEAT;
                    hit_nxt   = 1'b1;
                    score_nxt = 1'b1;
                    cnt_nxt   = 4'd0;
                end else if (tick) begin
                    pos_nxt = pos + 5'd1;
                    if ((pos + 5'd1) == MAX_P) begin
                        state_nxt = S_CONTACT;
                        cnt_nxt   = 4'd0;
                    end
                end
            end
            S_CONTACT: begin
                pos_nxt = MAX_P;
                hit_nxt = 1'b0;
                if (atk_edge) begin
                    state_nxt = S_DEFEAT;
                    hit_nxt   = 1'b1;
                    score_nxt = 1'b1;
                    cnt_nxt   = 4'd0;
                end else if (tick) begin
                    if (cnt == CT_LAST) begin
                        state_nxt = S_IDLE;
                        pos_nxt   = 5'd0;
                        hit_nxt   = 1'b1;
                        miss_nxt  = 1'b1;
                        cnt_nxt   = 4'd0;
                    end else begin
                        cnt_nxt = cnt + 4'd1;
                    end
                end
            end
            S_DEFEAT: begin
                hit_nxt = 1'b1;
                if (tick) begin
                    if (cnt == DT_LAST) begin
                        state_nxt = S_IDLE;
                        pos_nxt   = 5'd0;
                        cnt_nxt   = 4'd0;
                    end else begin
                        cnt_nxt = cnt + 4'd1;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                pos_nxt   = 5'd0;
                hit_nxt   = 1'b1;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_enemy_lane_ctrl.sv
// Purpose: self-checking bench for enemy_lane_ctrl: directed scenarios then random traffic vs a reference model.
// Latency: outputs compared 1 time unit after every rising edge against the model advanced on that edge.
// Backpressure: not applicable; inputs are driven freely every cycle.
module tb_enemy_lane_ctrl;

    localparam int MAX_POS       = 10;
    localparam int HIT_LO        = 7;
    localparam int DEFEAT_TICKS  = 4;
    localparam int CONTACT_TICKS = 8;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       spawn;
    logic       attack;
    logic [4:0] pos;
    logic       hit;
    logic       score_pulse;
    logic       miss_pulse;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: where the enemy is, whether it was struck, ticks spent since contact/defeat.
    int m_pos      = 0;
    bit m_defeated = 0;
    int m_ticks    = 0;
    bit m_prev_atk = 0;
    bit m_score    = 0;
    bit m_miss     = 0;

    enemy_lane_ctrl #(
        .MAX_POS      (MAX_POS),
        .HIT_LO       (HIT_LO),
        .DEFEAT_TICKS (DEFEAT_TICKS),
        .CONTACT_TICKS(CONTACT_TICKS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .spawn      (spawn),
        .attack     (attack),
        .pos        (pos),
        .hit        (hit),
        .score_pulse(score_pulse),
        .miss_pulse (miss_pulse),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_step(input bit r, input bit s, input bit t, input bit a);
        bit press;
        press      = a && !m_prev_atk;
        m_prev_atk = a;
        m_score    = 0;
        m_miss     = 0;
        if (r) begin
            m_pos = 0; m_defeated = 0; m_ticks = 0; m_prev_atk = 0;
        end else if (m_pos == 0) begin
            if (s) begin
                m_pos = 1; m_defeated = 0; m_ticks = 0;
            end
        end else if (m_defeated) begin
            if (t) begin
                m_ticks++;
                if (m_ticks == DEFEAT_TICKS) begin
                    m_pos = 0; m_defeated = 0;
                end
            end
        end else if (press && m_pos >= HIT_LO) begin
            m_defeated = 1; m_ticks = 0; m_score = 1;
        end else if (t) begin
            if (m_pos < MAX_POS) begin
                m_pos++;
                m_ticks = 0;
            end else begin
                m_ticks++;
                if (m_ticks == CONTACT_TICKS) begin
                    m_pos = 0; m_miss = 1;
                end
            end
        end
    endtask

    // Drive one cycle of inputs, clock it, then compare every output with the model.
    task automatic step(input bit r, input bit s, input bit t, input bit a);
        rst = r; spawn = s; tick = t; attack = a;
        @(posedge clk);
        model_step(r, s, t, a);
        #1;
        check("pos",   int'(pos),         m_pos);
        check("hit",   int'(hit),         int'(m_pos == 0 || m_defeated));
        check("busy",  int'(busy),        int'(m_pos != 0));
        check("score", int'(score_pulse), int'(m_score));
        check("miss",  int'(miss_pulse),  int'(m_miss));
    endtask

    task automatic ticks(input int n, input bit a);
        for (int i = 0; i < n; i++) begin
            step(0, 0, 1, a);
            step(0, 0, 0, a);
        end
    endtask

    initial begin
        rst = 1; spawn = 0; tick = 0; attack = 0;
        #1;

        // Reset then idle.
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("rst_pos", int'(pos), 0);
        check("rst_hit", int'(hit), 1);
        ticks(20, 0);

        // Full walk to contact, then despawn as a miss.
        step(0, 1, 0, 0);
        ticks(9, 0);
        check("contact_pos", int'(pos), MAX_POS);
        ticks(8, 0);
        check("miss_done_pos", int'(pos), 0);

        // Early press ignored, held key does not re-fire, fresh press at 7 defeats.
        step(0, 1, 0, 0);
        ticks(3, 0);
        step(0, 0, 0, 1);
        ticks(3, 1);
        check("held_pos7", int'(pos), 7);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        check("defeat_score", int'(score_pulse), 1);
        check("defeat_pos7", int'(pos), 7);
        ticks(4, 1);
        step(0, 0, 0, 0);

        // Press coincident with the final contact tick wins over the miss.
        step(0, 1, 0, 0);
        ticks(9, 0);
        ticks(7, 0);
        step(0, 0, 1, 1);
        check("final_tick_score", int'(score_pulse), 1);
        check("final_tick_nomiss", int'(miss_pulse), 0);
        ticks(4, 0);

        // Coincident tick and press at 6 moves, at 7 defeats without moving.
        step(0, 1, 0, 0);
        ticks(5, 0);
        step(0, 0, 1, 1);
        check("coinc6_pos", int'(pos), 7);
        step(0, 0, 0, 0);
        step(0, 0, 1, 1);
        check("coinc7_pos", int'(pos), 7);
        ticks(4, 0);

        // Spawn while walking is dropped; reset mid-walk clears silently.
        step(0, 1, 0, 0);
        ticks(4, 0);
        step(0, 1, 0, 0);
        ticks(3, 0);
        check("walk_pos8", int'(pos), 8);
        step(1, 0, 0, 0);
        check("midrst_busy", int'(busy), 0);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 3) == 0) ? ~attack : attack);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/enemy_lane_ctrl.md
Name: enemy_lane_ctrl

Overview:
- Per-lane enemy controller that generates the pos and hit pair consumed by the enemy sprite/damage stage.
- Spawns an enemy on request and advances it from position 1 to MAX_POS, one step per tick.
- Resolves player attacks against a hit window and reports score and miss events.
- One instance per lane; its outputs connect directly to the sprite stage's pos_N and hit_N inputs.

Parameters:
MAX_POS, 10, contact position; the enemy reaches the player here.
HIT_LO, 7, lowest position at which an attack counts as a hit.
DEFEAT_TICKS, 4, ticks the defeated enemy stays on screen before the lane clears.
CONTACT_TICKS, 8, ticks the enemy remains in contact before it despawns as a miss.

Ports:
clk  in  1  system clock; single clock domain.
rst  in  1  synchronous reset, active-high.
tick  in  1  one-cycle movement enable from the slow divider.
spawn  in  1  one-cycle spawn request.
attack  in  1  raw level from the player key for this lane.
pos  out  5  enemy position: 0 = lane empty, 1..MAX_POS = on screen.
hit  out  1  1 = enemy absent or defeated (downstream suppresses damage).
score_pulse  out  1  one-cycle pulse on a successful hit.
miss_pulse  out  1  one-cycle pulse when a contact enemy despawns unhit.
busy  out  1  1 whenever the state is not IDLE.

Behaviour:
- Synchronous reset values: pos=0, hit=1, score_pulse=0, miss_pulse=0, busy=0, state=IDLE, counters=0, attack edge register=0.
- Reset asserted mid-operation forces IDLE at the next edge; no pulse is emitted on that edge.
- All outputs are registered.
- Attack edge: attack is sampled into a register each cycle. atk_edge = attack & ~attack_q. Only atk_edge is used; holding the key never re-fires.
- State IDLE: pos=0, hit=1.
  - spawn=1 -> WALK next cycle with pos=1, hit=0.
  - atk_edge is ignored.
- State WALK: hit=0.
  - Priority is rst > atk_edge > tick.
  - atk_edge with pos>=HIT_LO -> DEFEAT next cycle: hit=1, pos frozen, score_pulse=1 for exactly 1 cycle.
  - atk_edge with pos<HIT_LO is ignored and leaves no residue.
  - tick (no valid attack) -> pos+1.
  - If pos+1==MAX_POS -> CONTACT with pos=MAX_POS; the contact counter clears to 0.
  - When atk_edge and tick coincide, the attack is judged against the current pos and the move is dropped.
- State CONTACT: pos=MAX_POS, hit=0; downstream raises damage.
  - atk_edge -> DEFEAT as above, including score_pulse.
  - Each tick increments the contact counter.
  - When the counter reaches CONTACT_TICKS-1 and a tick arrives -> IDLE: pos=0, hit=1, miss_pulse=1 for 1 cycle.
  - If atk_edge and that final tick coincide, the attack wins: DEFEAT, no miss.
- State DEFEAT: hit=1, pos held at its defeat value.
  - Each tick increments the defeat counter.
  - After DEFEAT_TICKS ticks -> IDLE with pos=0; hit stays 1.
  - atk_edge is ignored.
- spawn while busy=1 is dropped; it is not queued.
- A spawn on the same cycle the FSM enters IDLE is also dropped; it is accepted only while already in IDLE.
- Counters are 4 bits wide. CONTACT_TICKS and DEFEAT_TICKS must be at least 1 and at most 15.
- pos never exceeds MAX_POS and never wraps.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then 20 ticks with no spawn -> pos=0, hit=1, busy=0, no pulses.
- Full walk, miss: spawn, then 9 ticks -> pos runs 1..10, CONTACT. After 8 more ticks -> pos=0, hit=1, miss_pulse high exactly 1 cycle, score_pulse never.
- Early attack ignored: spawn, 3 ticks (pos=4), attack edge -> no change. Attack held high through pos=7 -> no hit, because there is no new edge. Release and re-press at pos=7 -> DEFEAT, score_pulse 1 cycle, pos stays 7. After 4 ticks -> pos=0.
- Attack during contact, coincident with the final contact tick -> DEFEAT, score_pulse=1, miss_pulse=0.
- Coincident tick and attack edge at pos=6 -> ignored, pos becomes 7. Same event at pos=7 -> DEFEAT at pos 7, not 8.
- spawn during WALK at pos=5 -> ignored, pos continues 6. rst asserted at pos=8 -> next cycle pos=0, hit=1, busy=0, no pulses.
